tag_mem_arbiter: RTL
====================

Name: tag_mem_arbiter

Overview:
Controller in front of the 8192x4b 1w1r tag block RAM.
- After reset, sweeps every entry to a known value.
- Then shares the single write port between two write requesters and the single read port between two read requesters, each with round-robin arbitration.
- Never issues a same-cycle read and write to one address: the read is stalled instead, so the RAM's address-conflict assertion can never fire.

Parameters:
ADDR_W, 13, address width; depth = 2**ADDR_W
DATA_W, 4, tag word width; also width of the write mask
INIT_VAL, 4'b0000, value written to every entry during the init sweep

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  asynchronous, active-high reset
init_done  out  1  high once the init sweep has completed
wr0_req  in  1  write request, requester 0
wr0_addr  in  ADDR_W  write address, requester 0
wr0_data  in  DATA_W  write data, requester 0
wr0_mask  in  DATA_W  per-bit write mask, requester 0
wr0_gnt  out  1  write grant, requester 0
wr1_req/wr1_addr/wr1_data/wr1_mask/wr1_gnt  as wr0_*, requester 1
rd0_req  in  1  read request, requester 0
rd0_addr  in  ADDR_W  read address, requester 0
rd0_gnt  out  1  read grant, requester 0
rd0_rvalid  out  1  read data valid, requester 0
rd1_req/rd1_addr/rd1_gnt/rd1_rvalid  as rd0_*, requester 1
rdata  out  DATA_W  shared read-return data, qualified by rdN_rvalid
mem_ce0  out  1  RAM write-port enable
mem_a0  out  ADDR_W  RAM write-port address
mem_d0  out  DATA_W  RAM write-port data
mem_we0  out  1  RAM write enable
mem_wem0  out  DATA_W  RAM write mask
mem_ce1  out  1  RAM read-port enable
mem_a1  out  ADDR_W  RAM read-port address
mem_q1  in  DATA_W  RAM read data, valid one cycle after mem_ce1
conflict_cnt  out  16  read-stall counter (see Optional Feature)

Behaviour:
- Reset values: init_done=0, all gnt=0, all rvalid=0, both RR pointers=0, init counter=0, conflict_cnt=0.
- States: INIT, RUN. Reset (async, any time) forces INIT and clears all state immediately. There is no other return to INIT.
- INIT:
  - Each cycle drives mem_ce0=1, mem_we0=1, mem_wem0=all ones, mem_d0=INIT_VAL, mem_a0=counter; counter then increments.
  - No grants. mem_ce1=0.
  - After the write of address 2**ADDR_W-1, move to RUN; init_done=1 from the following cycle.
  - First RUN cycle = cycle 8192 after RST deasserts (cycle 0 = first edge).
- RUN write arbitration:
  - Combinational grant in the same cycle as the request.
  - Pointer p selects the preferred requester; if only one requests, it wins.
  - A granted write drives mem_ce0/we0=1 and the winner's addr/data/mask in that cycle.
  - After any grant, p = the other requester.
  - An ungranted requester holds req and its payload until granted.
- RUN read arbitration:
  - Independent pointer, same round-robin rule.
  - Granted read drives mem_ce1=1 and mem_a1.
  - Next cycle, that requester's rvalid=1 and rdata=mem_q1. rdata is undefined when no rvalid is high.
- Hazard rule:
  - If the read winner's address equals the granted write address in the same cycle: no read grant, mem_ce1=0, read pointer unchanged.
  - The write proceeds. The read is re-arbitrated next cycle and returns the post-write value.
- Back-to-back reads are allowed every cycle; at most one rvalid is high per cycle.
- Idle: mem_ce*=0; mem_a*, mem_d0 and mem_wem0 are driven to 0 when their port is idle.

Optional Feature:
- Macro: TAG_MEM_ARBITER_STATS_EN.
- Defined: conflict_cnt increments by 1 on every cycle in which the hazard rule suppresses a read; saturates at 16'hFFFF; cleared by RST.
- Undefined: conflict_cnt is tied to 0 and no counter logic is present.

Test Plan:
- Init sweep: deassert RST, requests held high -> no grants, mem_a0 counts 0..8191 with mem_d0=INIT_VAL; init_done=1 at cycle 8193; then reading 0x1ABC returns rdata=0.
- Write round-robin: wr0 and wr1 requesting continuously in RUN -> grants alternate wr0, wr1, wr0, ...; with only wr1 requesting, wr1 is granted every cycle.
- Read latency: rd0 reads 0x0005 after writing 4'hA with mask 4'hF -> rd0_rvalid exactly one cycle after rd0_gnt, rdata=4'hA.
- Masked write: 4'hF then 4'h0 with mask 4'h3 at 0x0100 -> read returns 4'hC.
- Hazard: write 0x0042 data 4'h7 and read 0x0042 in the same cycle -> rd_gnt=0 and mem_ce1=0 that cycle; granted next cycle; rdata=4'h7; conflict_cnt=1 when stats are enabled.
- Reset mid-operation: RST asserted during a RUN read -> rvalid and gnt drop asynchronously; init_done=0 and the sweep restarts from address 0.

Source files
------------

// File: rtl/tag_mem_arbiter.sv
// tag_mem_arbiter: front-end controller for the 2**ADDR_W x DATA_W 1w1r tag RAM.
//   After reset it sweeps every entry to INIT_VAL (INIT). It then shares the write
//   port between wr0/wr1 and the read port between rd0/rd1 (RUN). Each port has its
//   own round-robin pointer. A read that would hit the address being written in the
//   same cycle is stalled, so the RAM never sees a same-address read/write.
// Ports:
//   CLK, RST                : clock, asynchronous active-high reset
//   init_done               : high once the init sweep has completed
//   wrN_req/addr/data/mask  : write requests (N = 0,1), wrN_gnt same-cycle grant
//   rdN_req/addr            : read requests (N = 0,1), rdN_gnt same-cycle grant
//   rdN_rvalid, rdata       : read return, one cycle after the grant
//   mem_ce0/a0/d0/we0/wem0  : RAM write port
//   mem_ce1/a1, mem_q1      : RAM read port (q1 valid one cycle after ce1)
//   conflict_cnt            : saturating count of stalled reads
// Optional build macro: TAG_MEM_ARBITER_STATS_EN enables conflict_cnt; when it is
//   undefined conflict_cnt is tied to zero.
module tag_mem_arbiter #(
  parameter int unsigned       ADDR_W   = 13,
  parameter int unsigned       DATA_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              init_done,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic [DATA_W-1:0] wr0_mask,
  output logic              wr0_gnt,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic [DATA_W-1:0] wr1_mask,
  output logic              wr1_gnt,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_gnt,
  output logic              rd0_rvalid,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_gnt,
  output logic              rd1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ce0,
  output logic [ADDR_W-1:0] mem_a0,
  output logic [DATA_W-1:0] mem_d0,
  output logic              mem_we0,
  output logic [DATA_W-1:0] mem_wem0,
  output logic              mem_ce1,
  output logic [ADDR_W-1:0] mem_a1,
  input  logic [DATA_W-1:0] mem_q1,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              rd0_rvalid_q, rd0_rvalid_d;
  logic              rd1_rvalid_q, rd1_rvalid_d;

  // Arbitration helpers: *_sel = 1 means requester 1 wins
  logic              wr_any, wr_sel;
  logic              rd_any, rd_sel;
  logic [ADDR_W-1:0] wr_addr_sel, rd_addr_sel;
  logic              hazard_c;

  // Round-robin winner selection for both ports
  always_comb begin
    wr_any      = wr0_req | wr1_req;
    wr_sel      = (wr0_req & wr1_req) ? wr_ptr_q : wr1_req;
    wr_addr_sel = wr_sel ? wr1_addr : wr0_addr;
    rd_any      = rd0_req | rd1_req;
    rd_sel      = (rd0_req & rd1_req) ? rd_ptr_q : rd1_req;
    rd_addr_sel = rd_sel ? rd1_addr : rd0_addr;
  end

  // Next-state, grants and RAM port drive
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    init_done_d  = (state_q == ST_RUN);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd0_rvalid_d = 1'b0;
    rd1_rvalid_d = 1'b0;
    hazard_c     = 1'b0;
    wr0_gnt      = 1'b0;
    wr1_gnt      = 1'b0;
    rd0_gnt      = 1'b0;
    rd1_gnt      = 1'b0;
    mem_ce0      = 1'b0;
    mem_we0      = 1'b0;
    mem_a0       = '0;
    mem_d0       = '0;
    mem_wem0     = '0;
    mem_ce1      = 1'b0;
    mem_a1       = '0;

    unique case (state_q)
      ST_INIT: begin
        mem_ce0  = 1'b1;
        mem_we0  = 1'b1;
        mem_wem0 = '1;
        mem_d0   = INIT_VAL;
        mem_a0   = cnt_q;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (wr_any) begin
          wr0_gnt  = ~wr_sel;
          wr1_gnt  = wr_sel;
          mem_ce0  = 1'b1;
          mem_we0  = 1'b1;
          mem_a0   = wr_addr_sel;
          mem_d0   = wr_sel ? wr1_data : wr0_data;
          mem_wem0 = wr_sel ? wr1_mask : wr0_mask;
          wr_ptr_d = ~wr_sel;
        end

        // Read stalls (pointer kept) when it targets the address being written
        hazard_c = rd_any & wr_any & (rd_addr_sel == wr_addr_sel);

        if (rd_any && !hazard_c) begin
          rd0_gnt      = ~rd_sel;
          rd1_gnt      = rd_sel;
          mem_ce1      = 1'b1;
          mem_a1       = rd_addr_sel;
          rd0_rvalid_d = ~rd_sel;
          rd1_rvalid_d = rd_sel;
          rd_ptr_d     = ~rd_sel;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // State registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      init_done_q  <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      rd0_rvalid_q <= 1'b0;
      rd1_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_done_q  <= init_done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd0_rvalid_q <= rd0_rvalid_d;
      rd1_rvalid_q <= rd1_rvalid_d;
    end
  end

  assign init_done  = init_done_q;
  assign rd0_rvalid = rd0_rvalid_q;
  assign rd1_rvalid = rd1_rvalid_q;
  // RAM output already carries the one-cycle read latency
  assign rdata      = mem_q1;

`ifdef TAG_MEM_ARBITER_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating stalled-read counter
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (hazard_c && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      conflict_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule
